// File: rtl/rv3n_fetch_pkg.sv
// rtl/rv3n_fetch_pkg.sv - shared defaults and types for the rv3n fetch stage
`timescale 1ns/1ps
package rv3n_fetch_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int FETCH_DEPTH_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/rv3n_fetch_fifo.sv
// rtl/rv3n_fetch_fifo.sv - synchronous FIFO with flush, used for fetched words and in-flight PCs
`timescale 1ns/1ps
module rv3n_fetch_fifo #(
    parameter int  W     = 64,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [AW:0]   count,
    output logic [W-1:0]  head_data
);

    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok, pop_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok   = push && (count != FULL_CNT) && !flush;
    assign pop_ok    = pop && (count != '0) && !flush;

    // Next-pointer logic; a flush discards everything including this cycle's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rv3n_fetch.sv
// rtl/rv3n_fetch.sv - instruction fetch stage with credit-limited prefetch and redirect flush
`timescale 1ns/1ps
module rv3n_fetch
    import rv3n_fetch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FETCH_DEPTH = FETCH_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_pc,
    input  logic             stage_id_clear,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [XLEN-1:0]  imem_resp_data,
    output logic             fetch_instr_valid,
    input  logic             fetch_instr_ready,
    output logic [XLEN-1:0]  fetch_instr_data,
    output logic [XLEN-1:0]  fetch_instr_pc
);

    localparam int          CW      = $clog2(FETCH_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = FETCH_DEPTH[CW:0];

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]      fifo_count, aq_count, out_next;
    logic [2*XLEN-1:0]  fifo_head;
    logic [XLEN-3:0]    aq_head;
    logic [CW:0]        credit_used;
    logic               flush, accept, resp_ok, keep, pop;

    // The in-flight PC queue doubles as the outstanding-request counter.
    assign flush          = jump_valid || stage_id_clear;
    assign credit_used    = {1'b0, fifo_count} + {1'b0, aq_count};
    assign imem_req_valid = (state_q == ST_RUN) && (credit_used < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && (aq_count != '0);
    assign keep           = resp_ok && (discard_q == '0) && !flush;
    assign pop            = fetch_instr_valid && fetch_instr_ready;
    assign out_next       = aq_count + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, resp_ok};

    assign fetch_instr_valid = (fifo_count != '0);
    assign fetch_instr_data  = fetch_instr_valid ? fifo_head[XLEN-1:0]      : '0;
    assign fetch_instr_pc    = fetch_instr_valid ? fifo_head[2*XLEN-1:XLEN] : '0;

    // Next state: redirect target, sequential PC advance and stale-response accounting.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        if (accept) pc_d = pc_q + XLEN'(4);
        if (jump_valid) begin
            pc_d    = jump_pc & {{(XLEN-2){1'b1}}, 2'b00};
            state_d = ST_RUN;
        end
        if (flush) begin
            discard_d = out_next;
        end else if (resp_ok && (discard_q != '0)) begin
            discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    rv3n_fetch_fifo #(
        .W     (2*XLEN),
        .DEPTH (FETCH_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (keep),
        .push_data ({aq_head, 2'b00, imem_resp_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    rv3n_fetch_fifo #(
        .W     (XLEN-2),
        .DEPTH (FETCH_DEPTH)
    ) u_addr_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc_q[XLEN-1:2]),
        .pop       (resp_ok),
        .count     (aq_count),
        .head_data (aq_head)
    );

endmodule

// File: tb/tb_rv3n_fetch.sv
// tb/tb_rv3n_fetch.sv - scoreboard bench for rv3n_fetch
`timescale 1ns/1ps
module tb_rv3n_fetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            jump_valid, stage_id_clear;
    logic [XLEN-1:0] jump_pc;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            fetch_instr_valid, fetch_instr_ready;
    logic [XLEN-1:0] fetch_instr_data, fetch_instr_pc;

    always #5 clk = ~clk;

    rv3n_fetch #(.XLEN(XLEN), .FETCH_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .jump_valid        (jump_valid),
        .jump_pc           (jump_pc),
        .stage_id_clear    (stage_id_clear),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .fetch_instr_valid (fetch_instr_valid),
        .fetch_instr_ready (fetch_instr_ready),
        .fetch_instr_data  (fetch_instr_data),
        .fetch_instr_pc    (fetch_instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    pend_t       pend[$];
    exp_t        expq[$];
    int          cyc, lat, n_assert, n_fail, n_acc, n_pop;
    bit          running;
    logic [31:0] model_pc, last_pop_pc, last_pop_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        bit    fl     = jump_valid || stage_id_clear;
        bit    rv_exp = running && (pend.size() + expq.size() < DEPTH);
        bit    have_resp = 1'b0;
        bit    acc;
        pend_t p;
        exp_t  e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            have_resp       = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(p.addr);
        end
        #1;
        check("req_valid", imem_req_valid, rv_exp);
        check("instr_valid", fetch_instr_valid, expq.size() != 0);
        if (fetch_instr_valid && fetch_instr_ready && expq.size() != 0) begin
            e = expq.pop_front();
            check("pop_pc", fetch_instr_pc, e.pc);
            check("pop_data", fetch_instr_data, e.data);
            last_pop_pc   = fetch_instr_pc;
            last_pop_data = fetch_instr_data;
            n_pop++;
        end
        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            check("req_addr", imem_req_addr, model_pc);
            pend.push_back('{addr: model_pc, due: cyc + lat, stale: fl});
            n_acc++;
        end
        if (have_resp && !p.stale && !fl) begin
            check("push_not_full", dut.fifo_count < DEPTH, 1);
            expq.push_back('{pc: p.addr, data: mem_word(p.addr)});
        end
        if (fl) begin
            expq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
        end
        if (jump_valid) begin
            model_pc = jump_pc & ~32'h3;
            running  = 1'b1;
        end else if (acc) begin
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst               = 1'b0;
        jump_valid        = 1'b0;
        jump_pc           = '0;
        stage_id_clear    = 1'b0;
        imem_req_ready    = 1'b0;
        imem_resp_valid   = 1'b0;
        imem_resp_data    = '0;
        fetch_instr_ready = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        pend.delete();
        expq.delete();
        running  = 1'b0;
        model_pc = '0;
        rst      = 1'b1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 0);
        check("rst_instr_valid", fetch_instr_valid, 0);
        check("rst_instr_data", fetch_instr_data, 0);
        check("rst_instr_pc", fetch_instr_pc, 0);
    endtask

    initial begin
        int          n;
        logic [31:0] saved_pc;
        cyc = 0; lat = 1; n_assert = 0; n_fail = 0; n_acc = 0; n_pop = 0;
        running = 1'b0; model_pc = '0; last_pop_pc = '0; last_pop_data = '0;
        rst = 1'b0; jump_valid = 1'b0; jump_pc = '0; stage_id_clear = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        fetch_instr_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // idle until the first redirect
        imem_req_ready = 1'b1; fetch_instr_ready = 1'b1;
        repeat (3) step();

        // streaming from 0x200 with 1-cycle memory
        jump_valid = 1'b1; jump_pc = 32'h200; step(); jump_valid = 1'b0;
        check("start_addr", imem_req_addr, 32'h200);
        repeat (20) step();

        // ID back-pressure fills the FIFO, then one pop buys one request
        fetch_instr_ready = 1'b0;
        repeat (12) step();
        check("stall_no_req", imem_req_valid, 0);
        check("stall_full", dut.fifo_count, DEPTH);
        n_acc = 0;
        fetch_instr_ready = 1'b1; step(); fetch_instr_ready = 1'b0;
        repeat (6) step();
        check("one_req", n_acc, 1);
        fetch_instr_ready = 1'b1;
        repeat (8) step();

        // three in flight at latency 3, then redirect to 0x400
        imem_req_ready = 1'b0; repeat (6) step();
        lat = 3; imem_req_ready = 1'b1;
        n = 0;
        while (pend.size() != 3 && n < 30) begin step(); n++; end
        check("three_outstanding", dut.aq_count, 3);
        jump_valid = 1'b1; jump_pc = 32'h400; step(); jump_valid = 1'b0;
        n_pop = 0; n = 0;
        while (n_pop == 0 && n < 30) begin step(); n++; end
        check("first_after_jump_pc", last_pop_pc, 32'h400);
        check("first_after_jump_data", last_pop_data, mem_word(32'h400));

        // misaligned redirect target
        lat = 1;
        jump_valid = 1'b1; jump_pc = 32'h403; step(); jump_valid = 1'b0;
        check("jump_align", imem_req_addr, 32'h400);
        repeat (10) step();

        // stage_id_clear with two buffered and one outstanding
        imem_req_ready = 1'b0; repeat (6) step();
        lat = 2; fetch_instr_ready = 1'b0;
        n = 0;
        while (!(expq.size() == 2 && pend.size() == 1) && n < 40) begin
            imem_req_ready = (pend.size() + expq.size() < 3);
            step(); n++;
        end
        check("buffered_two", dut.fifo_count, 2);
        check("outstanding_one", dut.aq_count, 1);
        saved_pc = model_pc;
        imem_req_ready = 1'b0; stage_id_clear = 1'b1; step(); stage_id_clear = 1'b0;
        check("clear_empties", fetch_instr_valid, 0);
        check("clear_pc_kept", imem_req_addr, saved_pc);
        fetch_instr_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (10) step();

        // reset with two outstanding
        imem_req_ready = 1'b0; repeat (6) step();
        lat = 3; imem_req_ready = 1'b1;
        n = 0;
        while (pend.size() != 2 && n < 30) begin step(); n++; end
        check("two_outstanding", dut.aq_count, 2);
        do_reset();
        imem_req_ready = 1'b1; fetch_instr_ready = 1'b1;
        repeat (5) step();
        check("idle_after_reset", imem_req_valid, 0);
        lat = 1;
        jump_valid = 1'b1; jump_pc = 32'h600; step(); jump_valid = 1'b0;
        repeat (15) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
